// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer.
// Pulses the PLL reset and waits for the PLL to lock. It then requires the lock
// to stay stable before it releases the system reset. A lost lock restarts the
// sequence. Repeated lock timeouts end in a latched FAULT state, which only a
// soft reset request or rst can clear. Every output is registered.
`timescale 1ns/1ps

module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,     // 1..65535
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,  // 2..65535
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,   // 1..65535
  parameter int unsigned MAX_RETRIES         = 3       // 0..15
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  // Terminal counts, pre-cast to the counter widths.
  localparam logic [15:0] RST_LAST     = 16'(RST_PULSE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
  // STABILIZE counts every lk=1 cycle. It moves to RUN on the following
  // confirming edge. So ready rises LOCK_STABLE_CYCLES+3 edges after the
  // first sampled lock: 2 synchronizer edges, 1 WAIT_LOCK exit edge, and the
  // stable run itself.
  localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYCLES);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

  // Lock synchronizer
  logic lk_meta_q;
  logic lk_q;

  // Sequencer state
  state_e      state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  loss_q,  loss_d;

  // Registered outputs
  logic pll_rst_q, pll_rst_d;
  logic sys_rst_q, sys_rst_d;
  logic ready_q,   ready_d;
  logic fault_q,   fault_d;

  // Two-flop synchronizer bringing the asynchronous lock indication into refclk.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let lk_q take the old lk_meta_q value,
      // which forms the second synchronizer stage. Blocking assignments here
      // would collapse both flops into one.
      lk_meta_q <= pll_locked;
      lk_q      <= lk_meta_q;
    end
  end

  // State register, in-state cycle counter and event counters.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_PLL;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state logic. A soft reset request outranks every in-state event.
  always_comb begin
    // NOTE: each variable gets a default before the case statement. This keeps
    // paths that do not assign it from inferring a latch.
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (soft_reset_req) begin
      state_d = RESET_PLL;
      retry_d = '0;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end

        WAIT_LOCK: begin
          if (lk_q) begin
            state_d = STABILIZE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q < RETRY_LIMIT) begin
              state_d = RESET_PLL;
              retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
            end else begin
              state_d = FAULT;
            end
          end
        end

        STABILIZE: begin
          // Any dropout sends the sequencer back to wait. The timeout
          // window then restarts from zero.
          if (!lk_q) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
          end
        end

        RUN: begin
          if (!lk_q) begin
            state_d = RESET_PLL;
            loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          end
        end

        FAULT: begin
          state_d = FAULT;
        end

        default: begin
          state_d = RESET_PLL;
        end
      endcase
    end

    // The counter clears on every state change. It also clears on a soft
    // restart that lands back in RESET_PLL, so that restart still produces a
    // full reset pulse. The counter saturates rather than wrapping while
    // parked in RUN or FAULT.
    if (soft_reset_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode from the next state, so the registered outputs switch on the same edge as the state.
  always_comb begin
    pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  // Output register. The reset values hold the PLL and the system in reset.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;

endmodule
